// File: rtl/req_splitter_pkg.sv
// Shared request types, widths and FSM state for the request splitter.
// Package name lynxTypes is kept so other blocks can share req_t.
package lynxTypes;

  localparam int PMTU_BYTES  = 4096;
  localparam int VADDR_BITS  = 48;
  localparam int LEN_BITS    = 28;
  localparam int OPCODE_BITS = 5;
  localparam int STRM_BITS   = 2;
  localparam int DEST_BITS   = 4;
  localparam int PID_BITS    = 6;
  localparam int VFID_BITS   = 4;
  localparam int OFFS_BITS   = 6;
  localparam int RSRVD_BITS  = 8;

  localparam int PARSE_SIZE_BITS = $clog2(PMTU_BYTES);

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } split_state_t;

  typedef struct packed {
    logic [OPCODE_BITS-1:0] opcode;
    logic [STRM_BITS-1:0]   strm;
    logic                   mode;
    logic                   rdma;
    logic                   remote;
    logic [VFID_BITS-1:0]   vfid;
    logic [PID_BITS-1:0]    pid;
    logic [DEST_BITS-1:0]   dest;
    logic                   host;
    logic                   actv;
    logic                   last;
    logic [VADDR_BITS-1:0]  vaddr;
    logic [LEN_BITS-1:0]    len;
    logic [OFFS_BITS-1:0]   offs;
    logic [RSRVD_BITS-1:0]  rsrvd;
  } req_t;

endpackage

// File: rtl/req_splitter_intf.sv
// valid/ready/data handshake bundle carrying one req_t.
// m drives valid/data, s drives ready.
interface metaIntf;
  import lynxTypes::*;

  logic valid;
  logic ready;
  req_t data;

  modport m (
    output valid,
    output data,
    input  ready
  );

  modport s (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/req_splitter.sv
// Splits one request into PARSE_SIZE-byte chunks, no bubbles between chunks.
// Define REQ_SPLIT_ALIGN_EN to keep chunks inside PARSE_SIZE-aligned blocks.
module req_splitter
  import lynxTypes::*;
#(
  parameter int PARSE_SIZE = PMTU_BYTES,
  parameter int CNT_BITS   = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  metaIntf.s                  s_req,
  metaIntf.m                  m_req,
  output logic                busy,
  output logic [CNT_BITS-1:0] chunk_cnt,
  output logic [31:0]         req_done_cnt
);

  localparam int PSB = $clog2(PARSE_SIZE);
  localparam logic [LEN_BITS-1:0] PS_LEN =
    LEN_BITS'(PARSE_SIZE);

  split_state_t        state_q, state_d;
  req_t                req_q, req_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]         done_q, done_d;
  logic                rdy_en_q, rdy_en_d;

  logic [LEN_BITS-1:0] room;
  logic [LEN_BITS-1:0] chunk;
  logic                fin;
  logic                s_hs;
  logic                m_hs;
  req_t                m_out;

`ifdef REQ_SPLIT_ALIGN_EN
  assign room = PS_LEN
              - LEN_BITS'(req_q.vaddr[PSB-1:0]);
`else
  assign room = PS_LEN;
`endif

  // len_rem <= room also covers the zero-length request
  assign chunk = (req_q.len < room) ? req_q.len : room;
  assign fin   = (req_q.len == chunk);

  assign s_req.ready = rdy_en_q && (state_q == ST_IDLE);
  assign m_req.valid = (state_q == ST_SEND);
  assign s_hs = s_req.valid && s_req.ready;
  assign m_hs = m_req.valid && m_req.ready;

  always_comb begin
    m_out       = req_q;
    m_out.len   = chunk;
    m_out.last  = fin ? req_q.last : 1'b0;
    m_out.offs  = '0;
    m_out.rsrvd = '0;
  end

  assign m_req.data   = m_out;
  assign busy         = (state_q == ST_SEND);
  assign chunk_cnt    = cnt_q;
  assign req_done_cnt = done_q;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    rdy_en_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (s_hs) begin
          req_d   = s_req.data;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_hs) begin
          req_d.vaddr = req_q.vaddr
                      + VADDR_BITS'(chunk);
          req_d.len   = req_q.len - chunk;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (fin) begin
            state_d = ST_IDLE;
            done_d  = done_q + 32'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      cnt_q    <= '0;
      done_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      rdy_en_q <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_req_splitter.sv
// Bench for req_splitter: vector table plus hand sequences,
// chunks checked against a scoreboard queue.
module tb_req_splitter;
  import lynxTypes::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        busy;
  logic [15:0] chunk_cnt;
  logic [31:0] req_done_cnt;

  metaIntf s_if ();
  metaIntf m_if ();

  always #5 aclk = ~aclk;

  req_splitter #(
    .PARSE_SIZE(4096),
    .CNT_BITS  (16)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_req       (s_if),
    .m_req       (m_if),
    .busy        (busy),
    .chunk_cnt   (chunk_cnt),
    .req_done_cnt(req_done_cnt)
  );

  int   total    = 0;
  int   bad      = 0;
  int   done_exp = 0;
  req_t sb_q[$];
  req_t mon_e;

  typedef struct {
    logic [47:0] va;
    logic [27:0] len;
    logic        last;
    int          n_al;
    int          n_un;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic req_t mk(input req_t r,
                              input logic [47:0] va,
                              input logic [27:0] ln,
                              input logic lst);
    req_t c;
    c       = r;
    c.vaddr = va;
    c.len   = ln;
    c.last  = lst;
    c.offs  = '0;
    c.rsrvd = '0;
    return c;
  endfunction

  // reference chunking; returns the number of chunks queued
  function automatic int push_exp(input req_t r);
    logic [47:0] va;
    logic [27:0] rem, room, ch;
    int n;
    va  = r.vaddr;
    rem = r.len;
    n   = 0;
    do begin
`ifdef REQ_SPLIT_ALIGN_EN
      room = 28'h1000 - 28'(va[11:0]);
`else
      room = 28'h1000;
`endif
      ch = (rem < room) ? rem : room;
      sb_q.push_back(mk(r, va, ch,
                        (ch == rem) ? r.last : 1'b0));
      va  = va + 48'(ch);
      rem = rem - ch;
      n++;
    end while (rem != 0);
    return n;
  endfunction

  function automatic req_t rand_req(input logic [47:0] va,
                                    input logic [27:0] ln,
                                    input logic lst);
    req_t r;
    r.opcode = OPCODE_BITS'($urandom);
    r.strm   = STRM_BITS'($urandom);
    r.mode   = 1'($urandom);
    r.rdma   = 1'($urandom);
    r.remote = 1'($urandom);
    r.vfid   = VFID_BITS'($urandom);
    r.pid    = PID_BITS'($urandom);
    r.dest   = DEST_BITS'($urandom);
    r.host   = 1'($urandom);
    r.actv   = 1'($urandom);
    r.offs   = OFFS_BITS'($urandom_range(1, 63));
    r.rsrvd  = RSRVD_BITS'($urandom_range(1, 255));
    r.vaddr  = va;
    r.len    = ln;
    r.last   = lst;
    return r;
  endfunction

  task automatic send_req(input req_t r);
    int n;
    @(posedge aclk);
    #1;
    s_if.valid = 1'b1;
    s_if.data  = r;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!s_if.ready && n < 200);
    if (!s_if.ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got=ready0 want=ready1");
    end
    @(posedge aclk);
    #1;
    s_if.valid = 1'b0;
    done_exp++;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while ((busy || sb_q.size() != 0) && n < 500);
    if (busy || sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got=pending%0d want=0",
               nm, sb_q.size());
    end
    chk({nm, "_done"}, 64'(req_done_cnt), 64'(done_exp));
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      if (busy)
        chk("s_ready_in_send", 64'(s_if.ready), 64'd0);
      if (m_if.valid && m_if.ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_chunk: got va=%0h len=%0h want=none",
                   m_if.data.vaddr, m_if.data.len);
        end else begin
          mon_e = sb_q.pop_front();
          total++;
          if (m_if.data !== mon_e) begin
            bad++;
            $display("FAIL chunk: got va=%0h len=%0h last=%0b want va=%0h len=%0h last=%0b",
                     m_if.data.vaddr, m_if.data.len, m_if.data.last,
                     mon_e.vaddr, mon_e.len, mon_e.last);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    req_t r, r2;
    int   n, nx;

    tbl[0] = '{48'h1F00,         28'h2000, 1'b1, 3, 2};
    tbl[1] = '{48'h0,            28'h1000, 1'b0, 1, 1};
    tbl[2] = '{48'h0,            28'h1001, 1'b1, 2, 2};
    tbl[3] = '{48'h0FFF,         28'h2,    1'b0, 2, 1};
    tbl[4] = '{48'h5000,         28'h0,    1'b1, 1, 1};
    tbl[5] = '{48'hFFFFFFFFFF80, 28'h100,  1'b1, 2, 1};
    tbl[6] = '{48'h123,          28'h10,   1'b1, 1, 1};
    tbl[7] = '{48'h800,          28'h1800, 1'b0, 2, 2};

    s_if.valid = 1'b0;
    s_if.data  = '0;
    m_if.ready = 1'b1;
    aresetn    = 1'b1;
    #1 aresetn = 1'b0;
    #1;
    chk("rst_s_ready", 64'(s_if.ready), 64'd0);
    chk("rst_m_valid", 64'(m_if.valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_chunk_cnt", 64'(chunk_cnt), 64'd0);
    chk("rst_done_cnt", 64'(req_done_cnt), 64'd0);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("ready_after_rst", 64'(s_if.ready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      r = rand_req(tbl[i].va, tbl[i].len, tbl[i].last);
      n = push_exp(r);
      send_req(r);
      wait_idle($sformatf("tbl%0d", i));
`ifdef REQ_SPLIT_ALIGN_EN
      nx = tbl[i].n_al;
`else
      nx = tbl[i].n_un;
`endif
      chk($sformatf("tbl%0d_chunk_cnt", i),
          64'(chunk_cnt), 64'(nx));
    end

    // literal chunk list for the 0x1F00/0x2000 case
    r = rand_req(48'h1F00, 28'h2000, 1'b1);
`ifdef REQ_SPLIT_ALIGN_EN
    sb_q.push_back(mk(r, 48'h1F00, 28'h100,  1'b0));
    sb_q.push_back(mk(r, 48'h2000, 28'h1000, 1'b0));
    sb_q.push_back(mk(r, 48'h3000, 28'hF00,  1'b1));
    nx = 3;
`else
    sb_q.push_back(mk(r, 48'h1F00, 28'h1000, 1'b0));
    sb_q.push_back(mk(r, 48'h2F00, 28'h1000, 1'b1));
    nx = 2;
`endif
    send_req(r);
    wait_idle("split_lit");
    chk("split_lit_cnt", 64'(chunk_cnt), 64'(nx));

    // zero length: chunk valid right after the accept edge
    r = rand_req(48'h7000, 28'h0, 1'b1);
    sb_q.push_back(mk(r, 48'h7000, 28'h0, 1'b1));
    chk("zl_idle_valid", 64'(m_if.valid), 64'd0);
    send_req(r);
    chk("zl_valid", 64'(m_if.valid), 64'd1);
    chk("zl_len", 64'(m_if.data.len), 64'd0);
    chk("zl_last", 64'(m_if.data.last), 64'd1);
    @(posedge aclk);
    #1;
    chk("zl_busy_after", 64'(busy), 64'd0);
    chk("zl_ready_after", 64'(s_if.ready), 64'd1);
    wait_idle("zl");
    chk("zl_cnt", 64'(chunk_cnt), 64'd1);

    // downstream stall on chunk 2
    r = rand_req(48'h0, 28'h3000, 1'b0);
    sb_q.push_back(mk(r, 48'h0,    28'h1000, 1'b0));
    sb_q.push_back(mk(r, 48'h1000, 28'h1000, 1'b0));
    sb_q.push_back(mk(r, 48'h2000, 28'h1000, 1'b0));
    send_req(r);
    @(posedge aclk);
    #1;
    m_if.ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk("stall_valid", 64'(m_if.valid), 64'd1);
      chk("stall_va", 64'(m_if.data.vaddr), 64'h1000);
      chk("stall_len", 64'(m_if.data.len), 64'h1000);
      chk("stall_cnt", 64'(chunk_cnt), 64'd1);
    end
    @(posedge aclk);
    #1;
    m_if.ready = 1'b1;
    wait_idle("stall");
    chk("stall_cnt_end", 64'(chunk_cnt), 64'd3);

    // reset while a request is in flight
    r = rand_req(48'h100, 28'h3000, 1'b1);
    n = push_exp(r);
    send_req(r);
    @(posedge aclk);
    #1;
    m_if.ready = 1'b0;
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_if.valid), 64'd0);
    chk("mid_rst_s_ready", 64'(s_if.ready), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_cnt", 64'(chunk_cnt), 64'd0);
    chk("mid_rst_done", 64'(req_done_cnt), 64'd0);
    sb_q.delete();
    done_exp = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn    = 1'b1;
    m_if.ready = 1'b1;
    @(posedge aclk);
    #1;
    chk("post_rst_ready", 64'(s_if.ready), 64'd1);
    r = rand_req(48'h1F00, 28'h2000, 1'b1);
    n = push_exp(r);
    send_req(r);
    wait_idle("post_rst");
    chk("post_rst_cnt", 64'(chunk_cnt), 64'(n));

    // back to back requests
    r  = rand_req(48'h3F80, 28'h1100, 1'b0);
    r2 = rand_req(48'h9000, 28'h40,   1'b1);
    n  = push_exp(r);
    n  = push_exp(r2);
    send_req(r);
    send_req(r2);
    wait_idle("b2b");
    chk("b2b_cnt", 64'(chunk_cnt), 64'(n));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/req_splitter.md
REQ_SPLITTER -- requirements
Module: req_splitter

Interface
REQ-001 Parameter PARSE_SIZE, default PMTU_BYTES, chunk size in bytes; SHALL be a power of two, at least 64.
REQ-002 Parameter CNT_BITS, default 16, width of the per-request chunk counter.
REQ-003 Port aclk, input, 1: sole clock; all logic SHALL be synchronous to its rising edge.
REQ-004 Port aresetn, input, 1: reset, asynchronous and active-low.
REQ-005 Port s_req, metaIntf.s, req_t: incoming request (valid/ready/data).
REQ-006 Port m_req, metaIntf.m, req_t: outgoing chunked request (valid/ready/data).
REQ-007 Port busy, output, 1: high while a request is held.
REQ-008 Port chunk_cnt, output, CNT_BITS: chunks of the current request already accepted downstream.
REQ-009 Port req_done_cnt, output, 32: number of fully issued requests; wraps modulo 2^32.

Function
REQ-010 The FSM SHALL have exactly two states: ST_IDLE and ST_SEND.
REQ-011 ST_IDLE: s_req.ready=1; on s_req.valid, latch all req_t fields and go to ST_SEND, clearing chunk_cnt.
REQ-012 ST_SEND: m_req.valid=1 and s_req.ready=0; the first chunk SHALL be valid exactly one cycle after s_req is accepted.
REQ-013 Chunk length SHALL be min(len_rem, PARSE_SIZE - (vaddr_rem mod PARSE_SIZE)) with alignment enabled, and min(len_rem, PARSE_SIZE) otherwise.
REQ-014 Chunk length SHALL be computed combinationally from the registered remainder, so the block inserts no bubble between chunks.
REQ-015 Chunk fields: vaddr=vaddr_rem; len=chunk length; last=latched last on the final chunk, else 0; offs=0; rsrvd=0; all other fields copied from the latched request.
REQ-016 On an m_req handshake: vaddr_rem += chunk, len_rem -= chunk, and chunk_cnt increments, saturating at all-ones.
REQ-017 On the handshake of the final chunk (len_rem == chunk): return to ST_IDLE and increment req_done_cnt.
REQ-018 A zero-length request SHALL emit exactly one chunk with len=0 and the latched last.
REQ-019 While m_req.valid=1 and ready=0, all m_req.data SHALL stay stable.
REQ-020 Address arithmetic SHALL be VADDR_BITS wide and wrap silently; length arithmetic SHALL be LEN_BITS wide.
REQ-021 The block SHALL never accept a new request in the cycle that the final chunk of the previous request completes.
REQ-022 busy SHALL equal (state == ST_SEND).

Reset
REQ-023 Asserting aresetn SHALL immediately force ST_IDLE, m_req.valid=0, s_req.ready=0, chunk_cnt=0 and req_done_cnt=0, even mid-request; the in-flight request is dropped.
REQ-024 s_req.ready SHALL rise in the first cycle after aresetn deasserts.

Configuration
REQ-025 Macro REQ_SPLIT_ALIGN_EN: when defined, chunks never cross a PARSE_SIZE-aligned address boundary (REQ-013, first form); when undefined, chunks are fixed PARSE_SIZE blocks from the start address (second form).

Structure
REQ-026 The req_t fields, LEN_BITS and VADDR_BITS SHALL come from lynxTypes, along with a shared state enum typedef and a helper constant PARSE_SIZE_BITS = clog2(PARSE_SIZE).
REQ-027 The design SHALL be a single module; no sub-module is required.

Verification (PARSE_SIZE=4096)
REQ-028 Aligned mode: vaddr=0x1F00, len=0x2000, last=1 -> chunks (0x1F00,0x100,0), (0x2000,0x1000,0), (0x3000,0xF00,1); chunk_cnt ends at 3; req_done_cnt=1.
REQ-029 Unaligned mode, same stimulus -> chunks (0x1F00,0x1000,0), (0x2F00,0x1000,0), (0x3F00,0,...) must not appear; exactly 2 chunks, the second with last=1.
REQ-030 len=0, last=1 -> one chunk with len=0, last=1, one cycle after accept; back in ST_IDLE after the handshake.
REQ-031 m_req.ready held low for 5 cycles during chunk 2 -> data stable throughout; no chunk lost or duplicated.
REQ-032 aresetn pulsed low mid-request -> m_req.valid=0 asynchronously, counters=0, next request processed normally.
REQ-033 Two back-to-back requests with ready=1 -> no overlap; s_req.ready low for every cycle of ST_SEND.
